// File: rtl/stream_packer_if.sv
// ---------------------------------------------------------------------------
// stream_packer_if
// Bundles both handshakes of the width-converting packer.
//   Narrow side : in_valid, in_data[DATA_WIDTH], in_last  -> packer
//                 in_ready                                <- packer
//   Wide side   : out_valid, out_data[DATA_WIDTH*RATIO],
//                 out_count[CW], out_last                 <- packer
//                 out_ready                               -> packer
// Modports:
//   slave  - the packer itself
//   master - whoever drives the narrow stream and consumes the wide stream
// ---------------------------------------------------------------------------
interface stream_packer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int RATIO      = 4
);
  localparam int CW = $clog2(RATIO) + 1;

  logic                          in_valid;
  logic [DATA_WIDTH-1:0]         in_data;
  logic                          in_last;
  logic                          in_ready;
  logic                          out_valid;
  logic [DATA_WIDTH*RATIO-1:0]   out_data;
  logic [CW-1:0]                 out_count;
  logic                          out_last;
  logic                          out_ready;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_count, out_last
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_count, out_last
  );
endinterface

// File: rtl/stream_packer.sv
// ---------------------------------------------------------------------------
// stream_packer
// Packs RATIO consecutive DATA_WIDTH input words into one wide output word.
// An input word flagged in_last closes the wide word early; the number of
// valid lanes is reported on out_count and unused upper lanes are zero.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous reset, active low
//   bus  - stream_packer_if.slave carrying both handshakes
// A single register holds the word under assembly and, once complete, the
// word being presented, so in_ready drops only while a finished word is
// stalled by the consumer.
// ---------------------------------------------------------------------------
module stream_packer #(
  parameter int DATA_WIDTH = 32,
  parameter int RATIO      = 4
) (
  input  logic            clk,
  input  logic            rst,
  stream_packer_if.slave  bus
);
  localparam int CW = $clog2(RATIO) + 1;
  localparam int IW = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int WW = DATA_WIDTH * RATIO;
  localparam logic [IW-1:0] LAST_LANE = IW'(RATIO - 1);

  logic          r_valid;
  logic          r_last;
  logic [WW-1:0] r_data;
  logic [CW-1:0] r_count;
  logic [IW-1:0] r_idx;

  logic          w_in_ready;
  logic          w_accept;
  logic          w_take;
  logic [IW-1:0] w_lane;
  logic          w_complete;
  logic [WW-1:0] w_data_next;

  // Combinational ready: a stalled complete word is the only reason to block.
  assign w_in_ready = ~r_valid | bus.out_ready;
  assign w_accept   = bus.in_valid & w_in_ready;
  assign w_take     = r_valid & bus.out_ready;

  // Accepting while r_valid implies the held word is draining on this edge,
  // so the new beat starts a fresh word in lane 0.
  assign w_lane     = r_valid ? '0 : r_idx;
  assign w_complete = (w_lane == LAST_LANE) | bus.in_last;

  genvar gi;
  generate
    for (gi = 0; gi < RATIO; gi++) begin : g_lane
      assign w_data_next[gi*DATA_WIDTH +: DATA_WIDTH] =
        (w_lane == IW'(gi)) ? bus.in_data :
        (r_valid ? '0 : r_data[gi*DATA_WIDTH +: DATA_WIDTH]);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_data  <= '0;
      r_count <= '0;
      r_idx   <= '0;
    end else if (w_accept) begin
      r_data <= w_data_next;
      if (w_complete) begin
        r_valid <= 1'b1;
        r_count <= CW'(w_lane) + CW'(1);
        r_last  <= bus.in_last;
        r_idx   <= '0;
      end else begin
        r_valid <= 1'b0;
        r_count <= '0;
        r_last  <= 1'b0;
        r_idx   <= w_lane + IW'(1);
      end
    end else if (w_take) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_count <= '0;
      r_last  <= 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_valid;
  assign bus.out_data  = r_data;
  assign bus.out_count = r_count;
  assign bus.out_last  = r_last;
endmodule

// File: tb/tb_stream_packer.sv
module tb_stream_packer;
  typedef struct packed {
    logic [31:0] data;
    logic [2:0]  count;
    logic        last;
  } exp_t;

  logic clk;
  logic rst_n;
  int   tests_run = 0;
  int   tests_failed = 0;
  int   stall_cycles = 0;

  exp_t        sb_q[$];
  logic [31:0] m_data = '0;
  int          m_idx = 0;

  stream_packer_if #(.DATA_WIDTH(8), .RATIO(4)) if4 ();
  stream_packer_if #(.DATA_WIDTH(8), .RATIO(1)) if1 ();

  stream_packer #(.DATA_WIDTH(8), .RATIO(4)) u_dut4 (
    .clk (clk),
    .rst (rst_n),
    .bus (if4)
  );

  stream_packer #(.DATA_WIDTH(8), .RATIO(1)) u_dut1 (
    .clk (clk),
    .rst (rst_n),
    .bus (if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every wide beat handed downstream is compared against the
  // oldest expectation pushed by the driver's reference model.
  always @(negedge clk) begin
    if (rst_n && if4.out_valid && if4.out_ready) begin
      exp_t e;
      tests_run++;
      if (sb_q.size() == 0) begin
        tests_failed++;
        $display("FAIL sb_unexpected: got data=%h count=%0d last=%0b, required no beat",
                 if4.out_data, if4.out_count, if4.out_last);
      end else begin
        e = sb_q.pop_front();
        if (if4.out_data !== e.data || if4.out_count !== e.count || if4.out_last !== e.last) begin
          tests_failed++;
          $display("FAIL sb_beat: got data=%h count=%0d last=%0b, required data=%h count=%0d last=%0b",
                   if4.out_data, if4.out_count, if4.out_last, e.data, e.count, e.last);
        end else begin
          $display("[TB] beat data=%h count=%0d last=%0b", if4.out_data, if4.out_count, if4.out_last);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive one narrow beat (called at posedge+1), wait for acceptance, update model.
  task automatic send4(input logic [7:0] d, input logic l);
    int waited = 0;
    exp_t e;
    if4.in_valid = 1'b1;
    if4.in_data  = d;
    if4.in_last  = l;
    @(negedge clk);
    while (!if4.in_ready && waited < 50) begin
      waited++;
      stall_cycles++;
      @(negedge clk);
    end
    if (!if4.in_ready) begin
      tests_run++;
      tests_failed++;
      $display("FAIL send_timeout: in_ready=%0b, required 1 within 50 cycles", if4.in_ready);
    end else begin
      m_data[m_idx*8 +: 8] = d;
      if (m_idx == 3 || l) begin
        e.data  = m_data;
        e.count = 3'(m_idx + 1);
        e.last  = l;
        sb_q.push_back(e);
        m_data = '0;
        m_idx  = 0;
      end else begin
        m_idx++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    if4.in_valid = 1'b0;
    if4.in_last  = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    if4.in_valid = 1'b0; if4.in_data = '0; if4.in_last = 1'b0; if4.out_ready = 1'b0;
    if1.in_valid = 1'b0; if1.in_data = '0; if1.in_last = 1'b0; if1.out_ready = 1'b1;
    #23;
    tests_run++;
    if (if4.out_valid !== 1'b0 || if4.out_data !== 32'h0 || if4.out_count !== 3'd0 ||
        if4.out_last !== 1'b0 || if4.in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_state: got v=%0b d=%h c=%0d l=%0b rdy=%0b, required 0,0,0,0,1",
               if4.out_valid, if4.out_data, if4.out_count, if4.out_last, if4.in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if (if4.in_ready !== 1'b1 || if4.out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_release: got rdy=%0b v=%0b, required rdy=1 v=0", if4.in_ready, if4.out_valid);
    end
    if4.out_ready = 1'b1;
    $display("[TB] test_reset done");
  endtask

  task automatic test_full_word();
    send4(8'h11, 1'b0);
    send4(8'h22, 1'b0);
    send4(8'h33, 1'b0);
    tests_run++;
    if (if4.out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL full_early_valid: got out_valid=%0b, required 0", if4.out_valid);
    end
    send4(8'h44, 1'b0);
    if4.in_valid = 1'b0;
    tests_run++;
    if (if4.out_valid !== 1'b1 || if4.out_data !== 32'h44332211 || if4.out_count !== 3'd4 || if4.out_last !== 1'b0) begin
      tests_failed++;
      $display("FAIL full_word: got v=%0b d=%h c=%0d l=%0b, required v=1 d=44332211 c=4 l=0",
               if4.out_valid, if4.out_data, if4.out_count, if4.out_last);
    end
    idle(2);
    $display("[TB] test_full_word done");
  endtask

  task automatic test_early_last();
    send4(8'hA1, 1'b0);
    send4(8'hA2, 1'b1);
    if4.in_valid = 1'b0;
    tests_run++;
    if (if4.out_valid !== 1'b1 || if4.out_data !== 32'h0000A2A1 || if4.out_count !== 3'd2 || if4.out_last !== 1'b1) begin
      tests_failed++;
      $display("FAIL early_last: got v=%0b d=%h c=%0d l=%0b, required v=1 d=0000a2a1 c=2 l=1",
               if4.out_valid, if4.out_data, if4.out_count, if4.out_last);
    end
    idle(1);
    send4(8'hB1, 1'b1);
    if4.in_valid = 1'b0;
    tests_run++;
    if (if4.out_data !== 32'h000000B1 || if4.out_count !== 3'd1) begin
      tests_failed++;
      $display("FAIL next_lane0: got d=%h c=%0d, required d=000000b1 c=1", if4.out_data, if4.out_count);
    end
    idle(2);
    $display("[TB] test_early_last done");
  endtask

  task automatic test_backpressure();
    if4.out_ready = 1'b0;
    send4(8'h01, 1'b0);
    send4(8'h02, 1'b0);
    send4(8'h03, 1'b0);
    send4(8'h04, 1'b0);
    if4.in_valid = 1'b1;
    if4.in_data  = 8'h99;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests_run++;
      if (if4.in_ready !== 1'b0 || if4.out_valid !== 1'b1 || if4.out_data !== 32'h04030201 ||
          if4.out_count !== 3'd4 || if4.out_last !== 1'b0) begin
        tests_failed++;
        $display("FAIL bp_hold[%0d]: got rdy=%0b v=%0b d=%h c=%0d l=%0b, required rdy=0 v=1 d=04030201 c=4 l=0",
                 i, if4.in_ready, if4.out_valid, if4.out_data, if4.out_count, if4.out_last);
      end
    end
    @(posedge clk); #1;
    if4.out_ready = 1'b1;
    send4(8'h55, 1'b0);
    if4.in_valid = 1'b0;
    tests_run++;
    if (if4.out_valid !== 1'b0 || if4.out_data !== 32'h00000055) begin
      tests_failed++;
      $display("FAIL bp_restart: got v=%0b d=%h, required v=0 d=00000055", if4.out_valid, if4.out_data);
    end
    send4(8'h56, 1'b1);
    idle(2);
    $display("[TB] test_backpressure done");
  endtask

  task automatic test_back_to_back();
    stall_cycles = 0;
    for (int i = 1; i <= 12; i++) send4(8'(i), 1'b0);
    if4.in_valid = 1'b0;
    tests_run++;
    if (stall_cycles !== 0) begin
      tests_failed++;
      $display("FAIL b2b_stalls: got %0d stall cycles, required 0", stall_cycles);
    end
    tests_run++;
    if (if4.out_data !== 32'h0C0B0A09 || if4.out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_third: got v=%0b d=%h, required v=1 d=0c0b0a09", if4.out_valid, if4.out_data);
    end
    idle(2);
    $display("[TB] test_back_to_back done");
  endtask

  task automatic test_reset_midword();
    send4(8'h11, 1'b0);
    send4(8'h22, 1'b0);
    if4.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (if4.out_data !== 32'h0 || if4.out_valid !== 1'b0 || if4.out_count !== 3'd0 || if4.in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_reset: got d=%h v=%0b c=%0d rdy=%0b, required 0,0,0,1",
               if4.out_data, if4.out_valid, if4.out_count, if4.in_ready);
    end
    m_data = '0;
    m_idx  = 0;
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    send4(8'h33, 1'b0);
    send4(8'h44, 1'b0);
    send4(8'h55, 1'b0);
    send4(8'h66, 1'b0);
    if4.in_valid = 1'b0;
    tests_run++;
    if (if4.out_data !== 32'h66554433 || if4.out_count !== 3'd4) begin
      tests_failed++;
      $display("FAIL post_reset_word: got d=%h c=%0d, required d=66554433 c=4", if4.out_data, if4.out_count);
    end
    idle(2);
    $display("[TB] test_reset_midword done");
  endtask

  task automatic test_ratio1();
    if1.in_valid = 1'b1;
    if1.in_data  = 8'h7E;
    if1.in_last  = 1'b1;
    @(negedge clk);
    tests_run++;
    if (if1.in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL r1_ready: got %0b, required 1", if1.in_ready);
    end
    @(posedge clk); #1;
    if1.in_valid = 1'b0;
    if1.in_last  = 1'b0;
    tests_run++;
    if (if1.out_valid !== 1'b1 || if1.out_data !== 8'h7E || if1.out_count !== 1'b1 || if1.out_last !== 1'b1) begin
      tests_failed++;
      $display("FAIL r1_word: got v=%0b d=%h c=%0d l=%0b, required v=1 d=7e c=1 l=1",
               if1.out_valid, if1.out_data, if1.out_count, if1.out_last);
    end
    @(posedge clk); #1;
    tests_run++;
    if (if1.out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL r1_drain: got out_valid=%0b, required 0", if1.out_valid);
    end
    $display("[TB] test_ratio1 done");
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_early_last();
    test_backpressure();
    test_back_to_back();
    test_reset_midword();
    test_ratio1();
    idle(3);
    tests_run++;
    if (sb_q.size() != 0) begin
      tests_failed++;
      $display("FAIL sb_leftover: got %0d pending beats, required 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
